player_iter: RTL

PLAYER_ITER -- requirements
Module: player_iter

---
 rtl/player_pkg.sv | 21 ++
 rtl/player_if.sv | 48 ++++
 rtl/player_perm.sv | 36 +++
 rtl/player_iter.sv | 88 ++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types, defaults and index helper for the iterated bit permutation.
// Optional inverse mode is enabled with PLAYER_INVERSE_EN.
package player_pkg;

  localparam int P_WIDTH  = 64;
  localparam int P_ITER_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Top bit is a fixed point; the rest rotate by a multiply mod (w-1).
  function automatic int dest_idx(int i, int w, logic inv);
    if (i == w - 1) return i;
    if (inv) return (i * 4) % (w - 1);
    return (i * (w / 4)) % (w - 1);
  endfunction

endpackage

// File: rtl/player_if.sv
// Job/result handshake bundle for player_iter.
// Carries in_inv only when PLAYER_INVERSE_EN is defined.
interface player_if #(
  parameter int WIDTH  = 64,
  parameter int ITER_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [ITER_W-1:0] in_iter;
`ifdef PLAYER_INVERSE_EN
  logic              in_inv;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              busy;

  modport master (
`ifdef PLAYER_INVERSE_EN
    output in_inv,
`endif
    output in_valid,
    output in_data,
    output in_iter,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  modport slave (
`ifdef PLAYER_INVERSE_EN
    input  in_inv,
`endif
    input  in_valid,
    input  in_data,
    input  in_iter,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );

endinterface

// File: rtl/player_perm.sv
// One combinational application of the bit permutation.
// Inverse network is built only with PLAYER_INVERSE_EN.
module player_perm
  import player_pkg::*;
#(
  parameter int WIDTH = P_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             inv,
  output logic [WIDTH-1:0] permuted
);

  logic [WIDTH-1:0] fwd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fwd
    localparam int DF = dest_idx(i, WIDTH, 1'b0);
    assign fwd[DF] = data[i];
  end

`ifdef PLAYER_INVERSE_EN
  logic [WIDTH-1:0] rev;

  for (genvar j = 0; j < WIDTH; j++) begin : g_rev
    localparam int DR = dest_idx(j, WIDTH, 1'b1);
    assign rev[DR] = data[j];
  end

  assign permuted = inv ? rev : fwd;
`else
  logic unused_inv;

  assign unused_inv = inv;
  assign permuted   = fwd;
`endif

endmodule

// File: rtl/player_iter.sv
// Applies the bit permutation in_iter times per job, one per cycle.
// PLAYER_INVERSE_EN adds a per-job inverse mode.
module player_iter
  import player_pkg::*;
#(
  parameter int WIDTH  = P_WIDTH,
  parameter int ITER_W = P_ITER_W
) (
  input  logic clk,
  input  logic reset_n,
  player_if.slave io
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              inv_q;
  logic [WIDTH-1:0]  perm_out;

`ifdef PLAYER_INVERSE_EN
  logic inv_d;
`endif

  player_perm #(
    .WIDTH (WIDTH)
  ) u_perm (
    .data     (data_q),
    .inv      (inv_q),
    .permuted (perm_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef PLAYER_INVERSE_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          data_d  = io.in_data;
          cnt_d   = io.in_iter;
`ifdef PLAYER_INVERSE_EN
          inv_d   = io.in_inv;
`endif
          state_d = (io.in_iter == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        data_d = perm_out;
        cnt_d  = cnt_q - ITER_W'(1);
        if (cnt_q == ITER_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PLAYER_INVERSE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inv_q <= 1'b0;
    else          inv_q <= inv_d;
  end
`else
  assign inv_q = 1'b0;
`endif

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q == BUSY);
  assign io.out_data  = data_q;

endmodule
